divider: RTL and testbench

//  Sequential signed 32-bit divider for the CPU's div unit; the inverse of the

---
 rtl/divider_pkg.sv | 24 ++
 rtl/divider_if.sv | 33 +++
 rtl/divider_neg_abs.sv | 21 ++
 rtl/divider.sv | 162 ++++++++++++++++
 tb/tb_divider.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared constants and state encoding for the CPU divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int          DATA_W        = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Divider sequencer state encoding
  localparam logic [1:0]  DIV_IDLE = 2'd0;
  localparam logic [1:0]  DIV_RUN  = 2'd1;
  localparam logic [1:0]  DIV_FIX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_RUN  = DIV_RUN,
    ST_FIX  = DIV_FIX
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : divider_if
//  Purpose  : Control-unit <-> divider handshake and result bus.
//  Revision : 1.0  initial release
// ============================================================================
interface divider_if import cpu_pkg::*; #(
  parameter int WIDTH = DATA_W
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Control unit side
  modport master (
    output start, A, B,
    input  hi, lo, busy, done, div_zero
  );

  // Divider side
  modport slave (
    input  start, A, B,
    output hi, lo, busy, done, div_zero
  );

endinterface
`default_nettype wire

// File: rtl/divider_neg_abs.sv
`default_nettype none
// ============================================================================
//  Module   : neg_abs
//  Purpose  : Conditional two's-complement negate. Used both to take operand
//             magnitudes (neg_en = sign bit) and to re-apply result signs.
//  Revision : 1.0  initial release
// ============================================================================
module neg_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_en_i,
  output logic [WIDTH-1:0] out_o
);

  // Negation wraps modulo 2^WIDTH, so the most negative value maps to itself,
  // which read as unsigned is exactly its magnitude.
  assign out_o = neg_en_i ? (WIDTH'(0) - in_i) : in_i;

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module   : divider
//  Purpose  : Sequential signed divider, one radix-2 restoring step per cycle.
//             lo = quotient (truncated toward zero), hi = remainder (sign of A).
//  Revision : 1.0  initial release
// ============================================================================
module divider import cpu_pkg::*; #(
  parameter int WIDTH = DATA_W
) (
  input  logic     clock,
  input  logic     reset,
  divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             zero_q,  zero_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             dz_q,    dz_d;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH:0]   w_trial;

  neg_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in_i(bus.A), .neg_en_i(bus.A[WIDTH-1]), .out_o(w_abs_a)
  );
  neg_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in_i(bus.B), .neg_en_i(bus.B[WIDTH-1]), .out_o(w_abs_b)
  );
  neg_abs #(.WIDTH(WIDTH)) u_quo_fix (
    .in_i(quo_q), .neg_en_i(sign_q_q), .out_o(w_quo_fix)
  );
  neg_abs #(.WIDTH(WIDTH)) u_rem_fix (
    .in_i(rem_q), .neg_en_i(sign_r_q), .out_o(w_rem_fix)
  );

  // Trial subtract on the left-shifted partial remainder; one extra bit so the
  // borrow out is the sign. |B| <= 2^(WIDTH-1) keeps the shifted value in range.
  assign w_trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

  // Next-state: sequencer, step counter and shift/subtract datapath
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d   = 1'b1;
          dz_d     = 1'b0;
          count_d  = '0;
          sign_q_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          sign_r_d = bus.A[WIDTH-1];
          if (bus.B != '0) begin
            quo_d   = w_abs_a;
            div_d   = w_abs_b;
            rem_d   = '0;
            zero_d  = 1'b0;
            state_d = ST_RUN;
          end else begin
            // Raw dividend is parked in the quotient register for hi.
            quo_d   = bus.A;
            zero_d  = 1'b1;
            state_d = ST_FIX;
          end
        end
      end

      ST_RUN: begin
        quo_d   = {quo_q[WIDTH-2:0], ~w_trial[WIDTH]};
        rem_d   = w_trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                                 : w_trial[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (zero_q) begin
          lo_d = (WIDTH == DATA_W) ? WIDTH'(DIV_ZERO_QUOT) : {WIDTH{1'b1}};
          hi_d = quo_q;
          dz_d = 1'b1;
        end else begin
          lo_d = w_quo_fix;
          hi_d = w_rem_fix;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider
//  Purpose  : Self-checking bench for divider: transaction-level reference
//             model compared every cycle, plus directed literal cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference result: plain signed integer division on wide operands
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request completes a fixed number of
  // edges later; requests arriving while one is outstanding are dropped.
  int          m_cnt  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  logic        p_dz   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        {p_hi, p_lo} <= ref_div(bus.A, bus.B);
        p_dz   <= (bus.B == 32'd0);
        m_cnt  <= (bus.B == 32'd0) ? 1 : 33;
        m_busy <= 1'b1;
        m_dz   <= 1'b0;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     {31'd0, bus.busy},     {31'd0, m_busy});
      check("done",     {31'd0, bus.done},     {31'd0, m_done});
      check("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
      check("hi",       bus.hi,                m_hi);
      check("lo",       bus.lo,                m_lo);
    end
  end

  // One operation; A/B are scrambled after acceptance, optional ignored re-start
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output int lat, output logic dz);
    bit got;
    got = 1'b0; lat = 0; lo = '0; hi = '0; dz = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (inject && i == 5) begin
        bus.start = 1'b1; bus.A = 32'd1; bus.B = 32'd1;
      end else begin
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      end
      if (bus.done) begin
        got = 1'b1; lat = i; lo = bus.lo; hi = bus.hi; dz = bus.div_zero;
      end
    end
    bus.start = 1'b0;
    if (!got) check("op_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [31:0] lo, hi;
    int          lat;
    logic        dz;
    bit          saw_done;

    bus.start = 1'b0; bus.A = '0; bus.B = '0;

    // Pin the reference model with hand-computed results
    r = ref_div(32'd100, 32'd7);             check("ref_100_7", r[31:0], 32'd14);
    r = ref_div(32'hFFFF_FF9C, 32'd7);       check("ref_m100_7_hi", r[63:32], 32'hFFFF_FFFE);
    r = ref_div(32'h8000_0000, 32'hFFFF_FFFF); check("ref_min_m1", r[31:0], 32'h8000_0000);
    r = ref_div(32'd5, 32'd0);               check("ref_zero_hi", r[63:32], 32'd5);

    // Reset state
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, lo, hi, lat, dz);
    check("q_100_7", lo, 32'd14); check("r_100_7", hi, 32'd2); check("lat_100_7", lat, 32'd34);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b0, lo, hi, lat, dz);
    check("q_m100_7", lo, 32'hFFFF_FFF2); check("r_m100_7", hi, 32'hFFFF_FFFE);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b0, lo, hi, lat, dz);
    check("q_100_m7", lo, 32'hFFFF_FFF2); check("r_100_m7", hi, 32'd2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lo, hi, lat, dz);
    check("q_min_m1", lo, 32'h8000_0000); check("r_min_m1", hi, 32'd0);
    run_op(32'd3, 32'd5, 1'b0, lo, hi, lat, dz);
    check("q_3_5", lo, 32'd0); check("r_3_5", hi, 32'd3);
    run_op(32'd5, 32'd0, 1'b0, lo, hi, lat, dz);
    check("q_5_0", lo, 32'hFFFF_FFFF); check("r_5_0", hi, 32'd5);
    check("dz_5_0", {31'd0, dz}, 32'd1); check("lat_5_0", lat, 32'd2);
    run_op(32'd10, 32'd1, 1'b0, lo, hi, lat, dz);
    check("q_10_1", lo, 32'd10); check("dz_cleared", {31'd0, dz}, 32'd0);
    run_op(32'd100, 32'd7, 1'b1, lo, hi, lat, dz);
    check("q_ignored_start", lo, 32'd14); check("r_ignored_start", hi, 32'd2);

    // Reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    run_op(32'd100, 32'd7, 1'b0, lo, hi, lat, dz);
    check("q_after_rst", lo, 32'd14); check("r_after_rst", hi, 32'd2);

    // Randomized traffic, including starts while busy and on the done cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start = (($urandom % 3) == 0);
      bus.A = pick();
      bus.B = pick();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
